change_dispenser: RTL and testbench

Output-side companion to the coin-accepting vending FSM: takes the FSM's per-transaction result (`buy`, 2-bit change code `chg`) and physically services it. Releases the product with a one-cycle pulse, then pays the change as a series of 5 tk coins through a hopper handshake. Tracks the 5 tk coin inventory and refuses transactions it cannot fully pay. Sits between the vending FSM and the product/coin actuators.

---
 rtl/change_dispenser.sv | 122 ++++++++++++
 tb/tb_change_dispenser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Product/change dispenser: product pulse one cycle after req, then one 5 tk coin per hopper handshake.
// Waits on hop_ack for up to ACK_TIMEOUT cycles per coin; req is ignored while busy.
module change_dispenser #(
    parameter int COIN_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              buy,
    input  logic [1:0]        chg,
    input  logic              hop_ack,
    input  logic              refill,
    input  logic [COIN_W-1:0] refill_cnt,
    output logic              busy,
    output logic              prod_out,
    output logic              coin_out,
    output logic              done,
    output logic              err,
    output logic [COIN_W-1:0] coins_left
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PROD = 3'd1,
        COIN = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         rem_q, rem_d;
    logic [COIN_W-1:0]  coins_q, coins_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            coins_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coins_q <= coins_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coins_d = coins_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (req) begin
                    err_d = 1'b0;
                    // Admission check: only start what can be paid in full.
                    if (COIN_W'(chg) > coins_q) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d = chg;
                        if (buy)
                            state_d = PROD;
                        else if (chg != 2'd0)
                            state_d = COIN;
                        else
                            state_d = DONE;
                    end
                end else if (refill) begin
                    coins_d = refill_cnt;
                end
            end
            PROD: begin
                state_d = (rem_q != 2'd0) ? COIN : DONE;
            end
            COIN: begin
                if (hop_ack) begin
                    rem_d   = rem_q - 2'd1;
                    if (coins_q != '0)
                        coins_d = coins_q - COIN_W'(1);
                    tmo_d   = '0;
                    state_d = (rem_q == 2'd1) ? DONE : GAP;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    // Hopper stalled: abandon the unpaid remainder.
                    err_d   = 1'b1;
                    rem_d   = '0;
                    tmo_d   = '0;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                tmo_d   = '0;
                state_d = COIN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign prod_out   = (state_q == PROD);
    assign coin_out   = (state_q == COIN);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign coins_left = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: transaction table with a scoreboard queue plus reset/contention sequences.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       buy = 1'b0;
    logic [1:0] chg = 2'd0;
    logic       hop_ack = 1'b0;
    logic       refill = 1'b0;
    logic [7:0] refill_cnt = 8'd0;
    logic       busy, prod_out, coin_out, done, err;
    logic [7:0] coins_left;

    int n_checks = 0;
    int n_fail   = 0;

    change_dispenser #(.COIN_W(8), .ACK_TIMEOUT(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .buy        (buy),
        .chg        (chg),
        .hop_ack    (hop_ack),
        .refill     (refill),
        .refill_cnt (refill_cnt),
        .busy       (busy),
        .prod_out   (prod_out),
        .coin_out   (coin_out),
        .done       (done),
        .err        (err),
        .coins_left (coins_left)
    );

    always #5 clock = ~clock;

    // rmode: 0 no refill, 1 refill the cycle before req, 2 refill coincident with req.
    // dly: cycles coin_out is held before the hopper acks (255 = never).
    typedef struct {
        int rmode; int rval; int buy; int chg; int dly; int spam;
        int e_prod; int e_hs; int e_hi; int e_done; int e_err; int e_left;
        int e_busy1; int e_coin1; int e_donec;
    } vec_t;

    typedef struct {
        int prod; int hs; int hi; int dn; int err; int left;
        int busy1; int coin1; int donec;
    } obs_t;

    vec_t vt[9];
    vec_t sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        obs_t o;
        vec_t e;
        int   ack_cnt;
        int   finished;
        o = '{default: 0};
        ack_cnt  = 0;
        finished = 0;
        if (v.rmode == 1) begin
            refill = 1'b1;
            refill_cnt = 8'(v.rval);
            @(negedge clock);
            refill = 1'b0;
        end
        req = 1'b1;
        buy = v.buy[0];
        chg = 2'(v.chg);
        if (v.rmode == 2) begin
            refill = 1'b1;
            refill_cnt = 8'(v.rval);
        end
        sb_q.push_back(v);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clock);
            req = 1'b0;
            refill = 1'b0;
            if (cyc == 1) o.busy1 = int'(busy);
            if (prod_out) o.prod++;
            if (coin_out) begin
                o.hi++;
                if (o.coin1 == 0) o.coin1 = cyc;
                if (ack_cnt >= v.dly) begin
                    hop_ack = 1'b1;
                    o.hs++;
                    ack_cnt = 0;
                end else begin
                    hop_ack = 1'b0;
                    ack_cnt++;
                end
            end else begin
                hop_ack = 1'b0;
                ack_cnt = 0;
            end
            if (done) begin
                o.dn++;
                if (o.donec == 0) o.donec = cyc;
            end
            if (v.spam != 0 && busy) begin
                req = 1'b1;
                buy = 1'b1;
                chg = 2'd3;
            end
            if (!busy && cyc >= 2) begin
                finished = 1;
                break;
            end
        end
        hop_ack = 1'b0;
        req = 1'b0;
        o.err  = int'(err);
        o.left = int'(coins_left);
        e = sb_q.pop_front();
        check($sformatf("v%0d_finished", idx), finished, 1);
        check($sformatf("v%0d_busy1", idx),    o.busy1, e.e_busy1);
        check($sformatf("v%0d_prod", idx),     o.prod,  e.e_prod);
        check($sformatf("v%0d_handshakes", idx), o.hs,  e.e_hs);
        check($sformatf("v%0d_coin_hi", idx),  o.hi,    e.e_hi);
        check($sformatf("v%0d_first_coin", idx), o.coin1, e.e_coin1);
        check($sformatf("v%0d_done_cnt", idx), o.dn,    e.e_done);
        check($sformatf("v%0d_done_cyc", idx), o.donec, e.e_donec);
        check($sformatf("v%0d_err", idx),      o.err,   e.e_err);
        check($sformatf("v%0d_coins_left", idx), o.left, e.e_left);
    endtask

    initial begin
        //          rm  rv  buy chg dly spm | prod hs hi dn err left busy1 coin1 donec
        vt[0] = '{1, 10,  1, 1,   0, 0,    1, 1,  1, 1, 0,   9,  1, 2,  3};  // normal vend
        vt[1] = '{1,  5,  1, 3,   3, 1,    1, 3, 12, 1, 0,   2,  1, 2, 16};  // max change, slow hopper, req spam
        vt[2] = '{1,  1,  1, 2,   0, 0,    0, 0,  0, 0, 1,   1,  0, 0,  0};  // insufficient inventory
        vt[3] = '{0,  0,  0, 1,   0, 0,    0, 1,  1, 1, 0,   0,  1, 1,  2};  // clears err, coin only
        vt[4] = '{0,  0,  0, 0,   0, 0,    0, 0,  0, 1, 0,   0,  1, 0,  1};  // no-op through DONE
        vt[5] = '{1, 200, 1, 3,   0, 0,    1, 3,  3, 1, 0, 197,  1, 2,  7};  // best case
        vt[6] = '{0,  0,  0, 2, 255, 0,    0, 0, 16, 1, 1, 197,  1, 1, 17};  // hopper timeout
        vt[7] = '{2, 50,  1, 0,   0, 0,    1, 0,  0, 1, 0, 197,  1, 0,  2};  // refill with req dropped
        vt[8] = '{0,  0,  1, 0,   0, 0,    1, 0,  0, 1, 0,   0,  1, 0,  2};  // after mid-txn reset

        repeat (2) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_prod", int'(prod_out), 0);
        check("rst_coin", int'(coin_out), 0);
        check("rst_done", int'(done), 0);
        check("rst_err",  int'(err), 0);
        check("rst_left", int'(coins_left), 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) run_txn(i, vt[i]);

        // hop_ack outside COIN must not touch the inventory
        hop_ack = 1'b1;
        repeat (3) @(negedge clock);
        hop_ack = 1'b0;
        check("idle_ack_left", int'(coins_left), 197);
        check("idle_ack_busy", int'(busy), 0);

        // Asynchronous reset in the middle of paying coins
        req = 1'b1; buy = 1'b0; chg = 2'd2;
        @(negedge clock);
        req = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 10 && seen == 0; k++) begin
                if (coin_out) seen = 1;
                else @(negedge clock);
            end
            check("mid_reach_coin", seen, 1);
        end
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_coin", int'(coin_out), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err",  int'(err), 0);
        check("mid_rst_left", int'(coins_left), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_txn(8, vt[8]);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
